branch_recovery_ctrl: RTL and testbench

- Consumes the branch execution unit's resolution outputs (valid, ROB tag, mispredict, target address).
- Runs the misprediction recovery sequence: squashes the ROB, reservation stations and rename state younger than the branch, then redirects fetch to the correct PC over a valid/ready handshake.
- Arbitrates overlapping mispredicts so that only the oldest in-flight mispredicting branch determines the final redirect.
- Sits between the branch unit and the front-end/ROB.

---
 rtl/branch_recovery_ctrl_pkg.sv | 27 ++
 rtl/branch_recovery_ctrl_if.sv | 36 +++
 rtl/branch_recovery_ctrl_rob_age_cmp.sv | 19 +
 rtl/branch_recovery_ctrl.sv | 110 +++++++++++
 tb/tb_branch_recovery_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_recovery_ctrl_pkg.sv
// Shared types and helpers for the branch misprediction recovery block:
// recovery FSM states, ROB age arithmetic and the branch-resolution bundle.
package branch_recovery_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } recovery_state_e;

  localparam int BR_DATA_WIDTH = 32;
  localparam int BR_ROB_WIDTH  = 4;

  typedef struct packed {
    logic                     valid;
    logic [BR_ROB_WIDTH-1:0]  rob_tag;
    logic                     mispredict;
    logic [BR_DATA_WIDTH-1:0] target;
  } br_resolution_t;

  // Distance from the ROB head, modulo the ROB size; smaller means older.
  function automatic int unsigned rob_age(int unsigned tag, int unsigned head,
                                          int unsigned width);
    return (tag - head) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/branch_recovery_ctrl_if.sv
// Bundle of branch-resolution inputs, fetch redirect handshake and recovery
// status outputs exchanged between the recovery controller and its neighbours.
interface branch_recovery_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
);
  logic                  i_br_valid;
  logic [ROB_WIDTH-1:0]  i_br_rob_tag;
  logic                  i_br_mispredict;
  logic [DATA_WIDTH-1:0] i_br_target;
  logic [ROB_WIDTH-1:0]  i_rob_head;
  logic                  i_redirect_ready;

  logic                  o_flush;
  logic [ROB_WIDTH-1:0]  o_flush_tag;
  logic                  o_redirect_valid;
  logic [DATA_WIDTH-1:0] o_redirect_pc;
  logic                  o_fetch_stall;
  logic                  o_busy;
  logic [CNT_WIDTH-1:0]  o_mispredict_count;

  modport slave (
    input  i_br_valid, i_br_rob_tag, i_br_mispredict, i_br_target,
           i_rob_head, i_redirect_ready,
    output o_flush, o_flush_tag, o_redirect_valid, o_redirect_pc,
           o_fetch_stall, o_busy, o_mispredict_count
  );

  modport master (
    output i_br_valid, i_br_rob_tag, i_br_mispredict, i_br_target,
           i_rob_head, i_redirect_ready,
    input  o_flush, o_flush_tag, o_redirect_valid, o_redirect_pc,
           o_fetch_stall, o_busy, o_mispredict_count
  );
endinterface

// File: rtl/branch_recovery_ctrl_rob_age_cmp.sv
// Combinational ROB age comparator: a_older is set when tag_a is strictly
// older than tag_b relative to the current ROB head, wrap-around included.
module rob_age_cmp
  import branch_recovery_ctrl_pkg::*;
#(
  parameter int ROB_WIDTH = 4
) (
  input  logic [ROB_WIDTH-1:0] tag_a,
  input  logic [ROB_WIDTH-1:0] tag_b,
  input  logic [ROB_WIDTH-1:0] head,
  output logic                 a_older
);

  always_comb begin
    a_older = rob_age(32'(tag_a), 32'(head), unsigned'(ROB_WIDTH)) <
              rob_age(32'(tag_b), 32'(head), unsigned'(ROB_WIDTH));
  end

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Misprediction recovery controller: flushes younger state, then redirects
// fetch; an older mispredict arriving mid-recovery restarts the sequence.
module branch_recovery_ctrl
  import branch_recovery_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_WIDTH    = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_recovery_ctrl_if.slave bus
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  recovery_state_e       state, state_next;
  logic [ROB_WIDTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [FC_W-1:0]       fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  mis_event;
  logic                  event_older;
  logic                  accept;

  rob_age_cmp #(.ROB_WIDTH(ROB_WIDTH)) u_age_cmp (
    .tag_a   (bus.i_br_rob_tag),
    .tag_b   (tag_q),
    .head    (bus.i_rob_head),
    .a_older (event_older)
  );

  // In IDLE any mispredict starts recovery; otherwise only an older one preempts.
  assign mis_event = bus.i_br_valid & bus.i_br_mispredict;
  assign accept    = mis_event & ((state == IDLE) | event_older);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tag_q   <= '0;
      pc_q    <= '0;
      fcnt_q  <= '0;
      count_q <= '0;
    end else begin
      state  <= state_next;
      tag_q  <= tag_d;
      pc_q   <= pc_d;
      fcnt_q <= fcnt_d;
      if (accept && (count_q != '1)) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    tag_d      = tag_q;
    pc_d       = pc_q;
    fcnt_d     = fcnt_q;
    case (state)
      IDLE: begin
        if (accept) state_next = FLUSH;
      end
      FLUSH: begin
        if (accept)              state_next = FLUSH;
        else if (fcnt_q == '0)   state_next = REDIRECT;
      end
      REDIRECT: begin
        // Preemption outranks a handshake completing in the same cycle.
        if (accept)                     state_next = FLUSH;
        else if (bus.i_redirect_ready)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (accept) begin
      tag_d  = bus.i_br_rob_tag;
      pc_d   = bus.i_br_target;
      fcnt_d = FC_W'(FLUSH_CYCLES - 1);
    end else if ((state == FLUSH) && (fcnt_q != '0)) begin
      fcnt_d = fcnt_q - 1'b1;
    end
  end

  always_comb begin
    bus.o_flush            = 1'b0;
    bus.o_flush_tag        = '0;
    bus.o_redirect_valid   = 1'b0;
    bus.o_redirect_pc      = '0;
    bus.o_fetch_stall      = 1'b0;
    bus.o_busy             = 1'b0;
    bus.o_mispredict_count = count_q;
    case (state)
      FLUSH: begin
        bus.o_flush       = 1'b1;
        bus.o_flush_tag   = tag_q;
        bus.o_fetch_stall = 1'b1;
        bus.o_busy        = 1'b1;
      end
      REDIRECT: begin
        bus.o_redirect_valid = 1'b1;
        bus.o_redirect_pc    = pc_q;
        bus.o_fetch_stall    = 1'b1;
        bus.o_busy           = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Self-checking bench for branch_recovery_ctrl: directed vector table, corner
// sequences, and randomized traffic against a queue-free behavioural model.
module tb_branch_recovery_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  branch_recovery_ctrl_if #(.DATA_WIDTH(32), .ROB_WIDTH(4), .CNT_WIDTH(16)) bus_a ();
  branch_recovery_ctrl_if #(.DATA_WIDTH(32), .ROB_WIDTH(4), .CNT_WIDTH(2))  bus_b ();

  assign bus_b.i_br_valid       = bus_a.i_br_valid;
  assign bus_b.i_br_rob_tag     = bus_a.i_br_rob_tag;
  assign bus_b.i_br_mispredict  = bus_a.i_br_mispredict;
  assign bus_b.i_br_target      = bus_a.i_br_target;
  assign bus_b.i_rob_head       = bus_a.i_rob_head;
  assign bus_b.i_redirect_ready = bus_a.i_redirect_ready;

  branch_recovery_ctrl #(.DATA_WIDTH(32), .ROB_WIDTH(4), .FLUSH_CYCLES(2), .CNT_WIDTH(16))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  // Second instance exercises the single-flush-cycle and counter-saturation corners.
  branch_recovery_ctrl #(.DATA_WIDTH(32), .ROB_WIDTH(4), .FLUSH_CYCLES(1), .CNT_WIDTH(2))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    bit          start;
    bit          valid;
    bit          mis;
    logic [3:0]  tag;
    logic [31:0] target;
    logic [3:0]  head;
    bit          ready;
    bit          e_flush;
    logic [3:0]  e_tag;
    bit          e_rv;
    logic [31:0] e_pc;
    bit          e_stall;
    int          e_cnt;
  } vec_t;

  function automatic vec_t v(bit st, bit val, bit mis, int tag, int tgt, int head, bit rdy,
                             bit ef, int et, bit erv, int epc, bit es, int ec);
    vec_t r;
    r.start = st; r.valid = val; r.mis = mis; r.tag = 4'(tag); r.target = 32'(tgt);
    r.head = 4'(head); r.ready = rdy; r.e_flush = ef; r.e_tag = 4'(et); r.e_rv = erv;
    r.e_pc = 32'(epc); r.e_stall = es; r.e_cnt = ec;
    return r;
  endfunction

  // Behavioural model: per instance, whether recovering, flush cycles left, latched branch.
  bit          m_active [2];
  int          m_left   [2];
  int          m_tag    [2];
  logic [31:0] m_pc     [2];
  int          m_cnt    [2];
  int          m_fl     [2] = '{2, 1};
  int          m_cmax   [2] = '{65535, 3};

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 0; m_left[d] = 0; m_tag[d] = 0; m_pc[d] = '0; m_cnt[d] = 0;
    end
  endtask

  task automatic modelStep(bit ev, int tag, logic [31:0] pc, int head, bit ready);
    for (int d = 0; d < 2; d++) begin
      bit older;
      older = ((tag - head) & 15) < ((m_tag[d] - head) & 15);
      if (ev && (!m_active[d] || older)) begin
        m_active[d] = 1; m_left[d] = m_fl[d]; m_tag[d] = tag; m_pc[d] = pc;
        if (m_cnt[d] < m_cmax[d]) m_cnt[d]++;
      end else if (m_active[d] && m_left[d] > 0) begin
        m_left[d]--;
      end else if (m_active[d] && ready) begin
        m_active[d] = 0;
      end
    end
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkMain(string n, bit ef, logic [3:0] et, bit erv, logic [31:0] epc,
                           bit es, int ec);
    checkOutput({n, ".flush"},     32'(bus_a.o_flush),            32'(ef));
    checkOutput({n, ".flush_tag"}, 32'(bus_a.o_flush_tag),        32'(et));
    checkOutput({n, ".rvalid"},    32'(bus_a.o_redirect_valid),   32'(erv));
    checkOutput({n, ".rpc"},       bus_a.o_redirect_pc,           epc);
    checkOutput({n, ".stall"},     32'(bus_a.o_fetch_stall),      32'(es));
    checkOutput({n, ".busy"},      32'(bus_a.o_busy),             32'(es));
    checkOutput({n, ".count"},     32'(bus_a.o_mispredict_count), 32'(ec));
  endtask

  task automatic applyStimulus(bit val, bit mis, logic [3:0] tag, logic [31:0] tgt,
                               logic [3:0] head, bit rdy);
    bus_a.i_br_valid = val; bus_a.i_br_mispredict = mis; bus_a.i_br_rob_tag = tag;
    bus_a.i_br_target = tgt; bus_a.i_rob_head = head; bus_a.i_redirect_ready = rdy;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  vec_t vecs[$];

  initial begin
    int idle_cycles;
    // Basic recovery, head 0, tag 5, target 0x100
    vecs.push_back(v(1, 1,1, 5,'h100, 0,1,  0,0,0,0,     0,0));
    vecs.push_back(v(0, 0,0, 0,0,     0,1,  1,5,0,0,     1,1));
    vecs.push_back(v(0, 0,0, 0,0,     0,1,  1,5,0,0,     1,1));
    vecs.push_back(v(0, 0,0, 0,0,     0,1,  0,0,1,'h100, 1,1));
    vecs.push_back(v(0, 0,0, 0,0,     0,1,  0,0,0,0,     0,1));
    // Correctly predicted resolutions leave the block idle
    vecs.push_back(v(1, 1,0, 7,'h500, 0,1,  0,0,0,0,     0,0));
    vecs.push_back(v(0, 1,0, 3,'h600, 0,1,  0,0,0,0,     0,0));
    vecs.push_back(v(0, 0,0, 0,0,     0,1,  0,0,0,0,     0,0));
    // Older branch (tag 4) preempts tag 9 during flush
    vecs.push_back(v(1, 1,1, 9,'h200, 0,1,  0,0,0,0,     0,0));
    vecs.push_back(v(0, 0,0, 0,0,     0,1,  1,9,0,0,     1,1));
    vecs.push_back(v(0, 1,1, 4,'h300, 0,1,  1,9,0,0,     1,1));
    vecs.push_back(v(0, 0,0, 0,0,     0,1,  1,4,0,0,     1,2));
    vecs.push_back(v(0, 0,0, 0,0,     0,1,  1,4,0,0,     1,2));
    vecs.push_back(v(0, 0,0, 0,0,     0,1,  0,0,1,'h300, 1,2));
    vecs.push_back(v(0, 0,0, 0,0,     0,1,  0,0,0,0,     0,2));
    // Head 14: tag 1 is younger than tag 15 and must be dropped
    vecs.push_back(v(1, 1,1,15,'h400,14,1,  0,0,0,0,     0,0));
    vecs.push_back(v(0, 1,1, 1,'h700,14,1,  1,15,0,0,    1,1));
    vecs.push_back(v(0, 0,0, 0,0,    14,1,  1,15,0,0,    1,1));
    vecs.push_back(v(0, 0,0, 0,0,    14,1,  0,0,1,'h400, 1,1));
    vecs.push_back(v(0, 0,0, 0,0,    14,1,  0,0,0,0,     0,1));

    doReset();
    foreach (vecs[i]) begin
      if (vecs[i].start) doReset();
      checkMain($sformatf("vec%0d", i), vecs[i].e_flush, vecs[i].e_tag, vecs[i].e_rv,
                vecs[i].e_pc, vecs[i].e_stall, vecs[i].e_cnt);
      applyStimulus(vecs[i].valid, vecs[i].mis, vecs[i].tag, vecs[i].target,
                    vecs[i].head, vecs[i].ready);
      @(negedge clk);
    end

    // Backpressure: fetch refuses cycles 3-6, accepts in cycle 7
    doReset();
    applyStimulus(1, 1, 5, 32'h100, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 8; c++) begin
      checkMain($sformatf("bp_c%0d", c), c <= 2, (c <= 2) ? 4'd5 : 4'd0,
                c >= 3 && c <= 7, (c >= 3 && c <= 7) ? 32'h100 : 32'h0, c <= 7, 1);
      applyStimulus(0, 0, 0, 0, 0, c == 7);
      @(negedge clk);
    end

    // Reset asserted in REDIRECT abandons the request immediately
    doReset();
    applyStimulus(1, 1, 5, 32'h100, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst.pre_rvalid", 32'(bus_a.o_redirect_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkMain("rst.async", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rst.after_c%0d", c), 32'(bus_a.o_redirect_valid), 32'd0);
    end

    // Five recoveries on the 2-bit counter instance, which also has one flush cycle
    doReset();
    for (int k = 1; k <= 5; k++) begin
      int flushes;
      flushes = 0;
      applyStimulus(1, 1, 4'(k), 32'h1000 + 32'(k), 0, 1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 1);
      idle_cycles = 0;
      while ((bus_a.o_busy || bus_b.o_busy) && idle_cycles < 10) begin
        if (bus_b.o_flush) flushes++;
        idle_cycles++;
        @(negedge clk);
      end
      checkOutput($sformatf("sat%0d.idle", k), 32'(bus_a.o_busy | bus_b.o_busy), 32'd0);
      checkOutput($sformatf("sat%0d.count_b", k), 32'(bus_b.o_mispredict_count),
                  (k < 3) ? 32'(k) : 32'd3);
      checkOutput($sformatf("sat%0d.count_a", k), 32'(bus_a.o_mispredict_count), 32'(k));
      checkOutput($sformatf("sat%0d.flushes_b", k), 32'(flushes), 32'd1);
    end

    // Randomized traffic on both instances against the model
    doReset();
    begin
      logic [3:0] head;
      head = 4'(($urandom));
      for (int c = 0; c < 400; c++) begin
        bit          val, mis, rdy;
        logic [3:0]  tag;
        logic [31:0] tgt;
        checkOutput($sformatf("rnd%0d.a.flush", c), 32'(bus_a.o_flush),
                    32'(m_active[0] && m_left[0] > 0));
        checkOutput($sformatf("rnd%0d.a.ftag", c), 32'(bus_a.o_flush_tag),
                    (m_active[0] && m_left[0] > 0) ? 32'(m_tag[0]) : 32'd0);
        checkOutput($sformatf("rnd%0d.a.rvalid", c), 32'(bus_a.o_redirect_valid),
                    32'(m_active[0] && m_left[0] == 0));
        checkOutput($sformatf("rnd%0d.a.rpc", c), bus_a.o_redirect_pc,
                    (m_active[0] && m_left[0] == 0) ? m_pc[0] : 32'd0);
        checkOutput($sformatf("rnd%0d.a.stall", c), 32'(bus_a.o_fetch_stall), 32'(m_active[0]));
        checkOutput($sformatf("rnd%0d.a.count", c), 32'(bus_a.o_mispredict_count), 32'(m_cnt[0]));
        checkOutput($sformatf("rnd%0d.b.flush", c), 32'(bus_b.o_flush),
                    32'(m_active[1] && m_left[1] > 0));
        checkOutput($sformatf("rnd%0d.b.rpc", c), bus_b.o_redirect_pc,
                    (m_active[1] && m_left[1] == 0) ? m_pc[1] : 32'd0);
        checkOutput($sformatf("rnd%0d.b.busy", c), 32'(bus_b.o_busy), 32'(m_active[1]));
        checkOutput($sformatf("rnd%0d.b.count", c), 32'(bus_b.o_mispredict_count), 32'(m_cnt[1]));
        if ($urandom_range(15) == 0) head = 4'($urandom);
        val = ($urandom_range(1) == 1);
        mis = ($urandom_range(2) == 0);
        tag = 4'($urandom);
        tgt = $urandom;
        rdy = ($urandom_range(1) == 1);
        applyStimulus(val, mis, tag, tgt, head, rdy);
        modelStep(val && mis, int'(tag), tgt, int'(head), rdy);
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
